// File: rtl/uart_rx_cmd_router.sv
// UART receive router: loopback FIFO feed or single-letter command lines
// decoded into one-cycle command pulses for the selected application.
module uart_rx_cmd_router #(
  parameter int TIMEOUT_CYC = 100_000_000,
  parameter int CNT_W       = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] sw,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       rx_full,
  output logic [7:0] lb_data,
  output logic       lb_push,
  output logic       lb_overflow,
  output logic [4:0] cmd_run,
  output logic [4:0] cmd_clear,
  output logic [4:0] cmd_up,
  output logic [4:0] cmd_down,
  output logic [4:0] cmd_send,
  output logic       cmd_err
);

  typedef enum logic [1:0] {IDLE, GOT_CMD, DISCARD} state_t;

  state_t           state, cur_st;
  logic [CNT_W-1:0] cnt, cur_cnt;
  logic [2:0]       sw_s1, mode, mode_q;
  logic [7:0]       cmd, rx_up;
  logic [4:0]       dest;
  logic             loopback, term, sensor, timeout;

  // Letters are folded to uppercase; other bytes pass unchanged
  assign rx_up    = (rx_data >= "a" && rx_data <= "z") ?
                    (rx_data & 8'hDF) : rx_data;
  assign term     = (rx_data == 8'h0D) || (rx_data == 8'h0A);
  assign loopback = (mode == 3'b000);
  assign sensor   = dest[3] | dest[4];

  always_comb begin
    dest = '0;
    case (mode)
      3'b001:        dest[0] = 1'b1;
      3'b010:        dest[1] = 1'b1;
      3'b011:        dest[2] = 1'b1;
      3'b100, 3'b110: dest[3] = 1'b1;
      3'b101, 3'b111: dest[4] = 1'b1;
      default:       dest = '0;
    endcase
  end

  // A mode change restarts the parser in the same cycle
  always_comb begin
    cur_st  = state;
    cur_cnt = cnt;
    if (mode != mode_q) begin
      cur_st  = IDLE;
      cur_cnt = '0;
    end
  end

  assign timeout = (cur_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_s1       <= '0;
      mode        <= '0;
      mode_q      <= '0;
      state       <= IDLE;
      cnt         <= '0;
      cmd         <= '0;
      lb_data     <= '0;
      lb_push     <= 1'b0;
      lb_overflow <= 1'b0;
      cmd_run     <= '0;
      cmd_clear   <= '0;
      cmd_up      <= '0;
      cmd_down    <= '0;
      cmd_send    <= '0;
      cmd_err     <= 1'b0;
    end else begin
      sw_s1       <= sw;
      mode        <= sw_s1;
      mode_q      <= mode;
      lb_push     <= 1'b0;
      lb_overflow <= 1'b0;
      cmd_run     <= '0;
      cmd_clear   <= '0;
      cmd_up      <= '0;
      cmd_down    <= '0;
      cmd_send    <= '0;
      cmd_err     <= 1'b0;
      if (loopback) begin
        state <= IDLE;
        cnt   <= '0;
        if (rx_done) begin
          if (rx_full) begin
            lb_overflow <= 1'b1;
          end else begin
            lb_data <= rx_data;
            lb_push <= 1'b1;
          end
        end
      end else if (rx_done) begin
        cnt <= '0;
        case (cur_st)
          IDLE: begin
            state <= IDLE;
            if (!term) begin
              cmd   <= rx_up;
              state <= GOT_CMD;
            end
          end
          GOT_CMD: begin
            if (term) begin
              state <= IDLE;
              case (cmd)
                "R":     cmd_run  <= dest;
                "G":     cmd_send <= dest;
                "C":     if (sensor) cmd_err <= 1'b1;
                         else cmd_clear <= dest;
                "U":     if (sensor) cmd_err <= 1'b1;
                         else cmd_up <= dest;
                "D":     if (sensor) cmd_err <= 1'b1;
                         else cmd_down <= dest;
                default: cmd_err <= 1'b1;
              endcase
            end else begin
              cmd_err <= 1'b1;
              state   <= DISCARD;
            end
          end
          default: state <= term ? IDLE : DISCARD;
        endcase
      end else if (cur_st == IDLE || timeout) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        state <= cur_st;
        cnt   <= cur_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cmd_router.sv
// Directed bench for uart_rx_cmd_router: vector table plus
// timeout, mode-change and reset-mid-line sequences.
module tb_uart_rx_cmd_router;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] sw;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_full;
  logic [7:0] lb_data;
  logic       lb_push, lb_overflow, cmd_err;
  logic [4:0] cmd_run, cmd_clear, cmd_up, cmd_down, cmd_send;

  int checks = 0;
  int errors = 0;

  uart_rx_cmd_router #(.TIMEOUT_CYC(20), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .sw(sw),
    .rx_data(rx_data), .rx_done(rx_done), .rx_full(rx_full),
    .lb_data(lb_data), .lb_push(lb_push), .lb_overflow(lb_overflow),
    .cmd_run(cmd_run), .cmd_clear(cmd_clear), .cmd_up(cmd_up),
    .cmd_down(cmd_down), .cmd_send(cmd_send), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sw;
    logic [7:0]  data;
    logic        full;
    logic [35:0] exp;
  } vec_t;

  vec_t tbl[22];

  function automatic logic [35:0] o(
    input logic [7:0] d, input logic p, input logic ov,
    input logic [4:0] r, input logic [4:0] c, input logic [4:0] u,
    input logic [4:0] dn, input logic [4:0] s, input logic e);
    return {d, p, ov, r, c, u, dn, s, e};
  endfunction

  function automatic logic [35:0] outs();
    return {lb_data, lb_push, lb_overflow, cmd_run, cmd_clear,
            cmd_up, cmd_down, cmd_send, cmd_err};
  endfunction

  task automatic chk(input string name, input logic [35:0] exp);
    logic [35:0] got;
    got = outs();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic set_mode(input logic [2:0] s);
    if (sw !== s) begin
      sw = s;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic f);
    rx_data = b;
    rx_full = f;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    rx_full = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{3'd0, 8'h41, 1'b0, o(8'h41, 1, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{3'd0, 8'h42, 1'b0, o(8'h42, 1, 0, 0, 0, 0, 0, 0, 0)};
    tbl[2]  = '{3'd0, 8'h55, 1'b1, o(8'h42, 0, 1, 0, 0, 0, 0, 0, 0)};
    tbl[3]  = '{3'd2, "r",   1'b0, o(8'h42, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[4]  = '{3'd2, 8'h0D, 1'b0, o(8'h42, 0, 0, 5'b00010, 0, 0, 0, 0, 0)};
    tbl[5]  = '{3'd2, 8'h0A, 1'b0, o(8'h42, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[6]  = '{3'd4, "U",   1'b0, o(8'h42, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[7]  = '{3'd4, 8'h0A, 1'b0, o(8'h42, 0, 0, 0, 0, 0, 0, 0, 1)};
    tbl[8]  = '{3'd4, "G",   1'b0, o(8'h42, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[9]  = '{3'd4, 8'h0A, 1'b0, o(8'h42, 0, 0, 0, 0, 0, 0, 5'b01000, 0)};
    tbl[10] = '{3'd1, "R",   1'b0, o(8'h42, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[11] = '{3'd1, "X",   1'b0, o(8'h42, 0, 0, 0, 0, 0, 0, 0, 1)};
    tbl[12] = '{3'd1, 8'h0A, 1'b0, o(8'h42, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[13] = '{3'd1, "C",   1'b0, o(8'h42, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[14] = '{3'd1, 8'h0A, 1'b0, o(8'h42, 0, 0, 0, 5'b00001, 0, 0, 0, 0)};
    tbl[15] = '{3'd3, "u",   1'b0, o(8'h42, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[16] = '{3'd3, 8'h0D, 1'b0, o(8'h42, 0, 0, 0, 0, 5'b00100, 0, 0, 0)};
    tbl[17] = '{3'd3, "d",   1'b0, o(8'h42, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[18] = '{3'd3, 8'h0A, 1'b0, o(8'h42, 0, 0, 0, 0, 0, 5'b00100, 0, 0)};
    tbl[19] = '{3'd7, "R",   1'b0, o(8'h42, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[20] = '{3'd7, 8'h0A, 1'b0, o(8'h42, 0, 0, 5'b10000, 0, 0, 0, 0, 0)};
    tbl[21] = '{3'd7, "Q",   1'b0, o(8'h42, 0, 0, 0, 0, 0, 0, 0, 0)};

    reset = 1'b1;
    sw = 3'd0;
    rx_data = 8'h00;
    rx_done = 1'b0;
    rx_full = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", 36'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 22; i++) begin
      set_mode(tbl[i].sw);
      send(tbl[i].data, tbl[i].full);
      chk($sformatf("vec%0d", i), tbl[i].exp);
      @(negedge clk);
      chk($sformatf("vec%0d_drop", i), {tbl[i].exp[35:28], 28'h0});
    end
    send(8'h0A, 1'b0);
    chk("q_err", o(8'h42, 0, 0, 0, 0, 0, 0, 0, 1));

    // Delay well under the timeout keeps the line alive
    set_mode(3'd3);
    send("R", 1'b0);
    repeat (10) @(negedge clk);
    send(8'h0A, 1'b0);
    chk("short_wait", o(8'h42, 0, 0, 5'b00100, 0, 0, 0, 0, 0));

    // Idle past the timeout discards the partial line
    send("R", 1'b0);
    repeat (25) @(negedge clk);
    send(8'h0A, 1'b0);
    chk("timeout", o(8'h42, 0, 0, 0, 0, 0, 0, 0, 0));
    send("G", 1'b0);
    send(8'h0D, 1'b0);
    chk("after_timeout", o(8'h42, 0, 0, 0, 0, 0, 0, 5'b00100, 0));

    send("R", 1'b0);
    set_mode(3'd1);
    send(8'h0A, 1'b0);
    chk("mode_change", o(8'h42, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("mode_change_quiet", o(8'h42, 0, 0, 0, 0, 0, 0, 0, 0));

    send("R", 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_mid_line", 36'h0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    send(8'h0A, 1'b0);
    chk("post_reset_lf", 36'h0);
    send("R", 1'b0);
    send(8'h0A, 1'b0);
    chk("post_reset_run", o(8'h00, 0, 0, 5'b00001, 0, 0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
